// File: rtl/fir_filter_sym_dec.sv
// Symmetric FIR: folded pre-add, loadable half coefficient table, integer decimation, round + saturate.
// Latency 4 cycles from accepted sample to dout_valid; no backpressure, a sample may be accepted every cycle.
module fir_filter_sym_dec #(
  parameter int N      = 16,
  parameter int WIDTH  = 14,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int DECIM  = 1,
  localparam int AW    = (N > 2) ? $clog2(N / 2) : 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic signed [WIDTH-1:0]  din,
  input  logic                     din_valid,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     dout_valid,
  output logic                     sat
);

  localparam int HALF  = N / 2;
  localparam int PREW  = WIDTH + 1;
  localparam int PW    = WIDTH + 1 + COEF_W;
  localparam int ACC_W = WIDTH + COEF_W + 1 + $clog2(HALF);
  localparam int RW    = ACC_W + 1;
  localparam int PHW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RSH   = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND  = (SHIFT > 0) ? (RW'(1) <<< RSH) : '0;
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic signed [WIDTH-1:0]  r_tap  [N];
  logic signed [COEF_W-1:0] r_coef [HALF];
  logic signed [PREW-1:0]   r_pre  [HALF];
  logic signed [PW-1:0]     r_prod [HALF];
  logic signed [ACC_W-1:0]  r_acc;
  logic [PHW-1:0]           r_ph;
  logic [3:0]               r_vld;

  logic                     w_accept;
  logic                     w_tag;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [RW-1:0]     w_rnd;
  logic signed [RW-1:0]     w_r;
  logic                     w_hi;
  logic                     w_lo;

  // flush wins over din_valid: the sample presented with flush is dropped
  assign w_accept = din_valid & ~flush;
  assign w_tag    = (r_ph == PHW'(DECIM - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < N; i++) r_tap[i] <= '0;
      r_ph <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) r_tap[i] <= '0;
      r_ph <= '0;
    end else if (din_valid) begin
      r_tap[0] <= din;
      for (int i = 1; i < N; i++) r_tap[i] <= r_tap[i-1];
      r_ph <= w_tag ? '0 : r_ph + PHW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < HALF; k++) r_coef[k] <= '0;
    end else if (coef_we && (int'(coef_addr) < HALF)) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < HALF; j++) w_sum = w_sum + ACC_W'(r_prod[j]);
  end

  // Rounding add is one bit wider than the accumulator so it can never wrap
  assign w_rnd = RW'(r_acc) + RND;
  assign w_r   = w_rnd >>> SHIFT;
  assign w_hi  = (w_r > MAXV);
  assign w_lo  = (w_r < MINV);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int j = 0; j < HALF; j++) begin
        r_pre[j]  <= '0;
        r_prod[j] <= '0;
      end
      r_acc      <= '0;
      r_vld      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sat        <= 1'b0;
    end else begin
      for (int j = 0; j < HALF; j++) begin
        r_pre[j]  <= PREW'(r_tap[j]) + PREW'(r_tap[N-1-j]);
        r_prod[j] <= PW'(r_pre[j]) * PW'(r_coef[j]);
      end
      r_acc <= w_sum;
      if (flush) begin
        r_vld      <= '0;
        dout_valid <= 1'b0;
      end else begin
        r_vld      <= {r_vld[2:0], w_accept & w_tag};
        dout_valid <= r_vld[3];
        if (r_vld[3]) begin
          dout <= w_hi ? MAXV[OUT_W-1:0] : (w_lo ? MINV[OUT_W-1:0] : w_r[OUT_W-1:0]);
          sat  <= w_hi | w_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_sym_dec.sv
// Directed bench for fir_filter_sym_dec: one DECIM=1 instance and one DECIM=4 instance on shared inputs.
module tb_fir_filter_sym_dec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                n_rst;
  logic signed [13:0]  din;
  logic                din_valid;
  logic                flush;
  logic                coef_we;
  logic [2:0]          coef_addr;
  logic signed [15:0]  coef_wdata;
  logic signed [15:0]  dout, dout4;
  logic                dout_valid, dout_valid4, sat, sat4;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] got_dat[$];
  logic               got_sat[$];
  int                 got_t4[$];
  int                 adj;
  bit                 cap_prev;

  localparam logic signed [15:0] LP  [8] = '{16'sd112, 16'sd243, 16'sd618, 16'sd1293,
                                             16'sd2217, 16'sd3225, 16'sd4089, 16'sd4587};
  localparam int                 IMP [8] = '{28, 61, 154, 323, 554, 806, 1022, 1147};

  fir_filter_sym_dec #(.N(16), .WIDTH(14), .COEF_W(16), .OUT_W(16), .SHIFT(15), .DECIM(1)) u_dut (
    .clk(clk), .n_rst(n_rst), .din(din), .din_valid(din_valid), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .dout(dout), .dout_valid(dout_valid), .sat(sat));

  fir_filter_sym_dec #(.N(16), .WIDTH(14), .COEF_W(16), .OUT_W(16), .SHIFT(15), .DECIM(4)) u_dec4 (
    .clk(clk), .n_rst(n_rst), .din(din), .din_valid(din_valid), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .dout(dout4), .dout_valid(dout_valid4), .sat(sat4));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_capture();
    got_dat.delete();
    got_sat.delete();
    got_t4.delete();
    adj = 0;
    cap_prev = 1'b0;
  endtask

  task automatic capture(input int t);
    if (dout_valid) begin
      got_dat.push_back(dout);
      got_sat.push_back(sat);
      if (cap_prev) adj++;
    end
    cap_prev = dout_valid;
    if (dout_valid4) got_t4.push_back(t);
  endtask

  task automatic run(input logic signed [13:0] d, input int n, input bit alt, input bit drain);
    int len;
    int tot;
    len = alt ? 2 * n : n;
    tot = drain ? len + 4 : len;
    clear_capture();
    for (int t = 0; t < tot; t++) begin
      din       = d;
      din_valid = (t < len) && (!alt || (t % 2 == 0));
      tick();
      capture(t);
    end
    if (drain) din_valid = 1'b0;
  endtask

  task automatic feed_impulse();
    clear_capture();
    for (int t = 0; t < 20; t++) begin
      din       = (t == 0) ? 14'sd8191 : 14'sd0;
      din_valid = (t < 16);
      tick();
      capture(t);
    end
    din_valid = 1'b0;
  endtask

  task automatic load_coefs(input bit lp);
    for (int k = 0; k < 8; k++) begin
      coef_we    = 1'b1;
      coef_addr  = 3'(k);
      coef_wdata = lp ? LP[k] : 16'sh7FFF;
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic test_reset();
    int  first;
    bit  saw4;
    n_rst = 1'b0; din = '0; din_valid = 1'b0; flush = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    for (int i = 0; i < 6; i++) begin
      din       = 14'(i * 1000 - 2500);
      din_valid = i[0];
      tick();
    end
    checks++; if (dout !== 16'sd0)    begin errors++; $display("FAIL reset_dout got %0d exp 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b exp 0", dout_valid); end
    checks++; if (sat !== 1'b0)        begin errors++; $display("FAIL reset_sat got %b exp 0", sat); end
    checks++; if (dout_valid4 !== 1'b0 || dout4 !== 16'sd0)
      begin errors++; $display("FAIL reset_dec4 got v=%b d=%0d exp v=0 d=0", dout_valid4, dout4); end
    n_rst = 1'b1;
    din_valid = 1'b0;
    tick();
    din = 14'sd1234; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    first = -1; saw4 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (dout_valid && first < 0) first = c;
      if (dout_valid4) saw4 = 1'b1;
    end
    checks++; if (first != 4)  begin errors++; $display("FAIL first_latency got %0d exp 4", first); end
    checks++; if (saw4 != 1'b0) begin errors++; $display("FAIL dec4_single_sample got strobe exp none"); end
    checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL zero_coef_dout got %0d exp 0", dout); end
  endtask

  task automatic test_impulse();
    int exp_v;
    load_coefs(1'b1);
    flush = 1'b1; tick(); flush = 1'b0;
    feed_impulse();
    checks++; if (got_dat.size() != 16) begin errors++; $display("FAIL impulse_count got %0d exp 16", got_dat.size()); end
    for (int i = 0; i < 16 && i < got_dat.size(); i++) begin
      exp_v = IMP[(i < 8) ? i : 15 - i];
      checks++;
      if (got_dat[i] !== exp_v || got_sat[i] !== 1'b0)
        begin errors++; $display("FAIL impulse[%0d] got %0d sat=%b exp %0d sat=0", i, got_dat[i], got_sat[i], exp_v); end
    end
  endtask

  task automatic test_dc_stalls();
    run(14'sd8191, 20, 1'b1, 1'b1);
    checks++; if (got_dat.size() != 20) begin errors++; $display("FAIL dc_pos_count got %0d exp 20", got_dat.size()); end
    checks++; if (adj != 0) begin errors++; $display("FAIL dc_pos_idle_strobe got %0d adjacent exp 0", adj); end
    for (int j = 15; j < got_dat.size(); j++) begin
      checks++;
      if (got_dat[j] !== 16'sd8191 || got_sat[j] !== 1'b0)
        begin errors++; $display("FAIL dc_pos[%0d] got %0d sat=%b exp 8191 sat=0", j, got_dat[j], got_sat[j]); end
    end
    run(-14'sd8192, 20, 1'b1, 1'b1);
    checks++; if (got_dat.size() != 20) begin errors++; $display("FAIL dc_neg_count got %0d exp 20", got_dat.size()); end
    checks++; if (adj != 0) begin errors++; $display("FAIL dc_neg_idle_strobe got %0d adjacent exp 0", adj); end
    for (int j = 15; j < got_dat.size(); j++) begin
      checks++;
      if (got_dat[j] !== -16'sd8192 || got_sat[j] !== 1'b0)
        begin errors++; $display("FAIL dc_neg[%0d] got %0d sat=%b exp -8192 sat=0", j, got_dat[j], got_sat[j]); end
    end
  endtask

  task automatic test_saturation();
    load_coefs(1'b0);
    run(14'sd8191, 16, 1'b0, 1'b1);
    checks++; if (got_dat.size() != 16) begin errors++; $display("FAIL sat_count got %0d exp 16", got_dat.size()); end
    checks++; if (got_dat[$] !== 16'sh7FFF || got_sat[$] !== 1'b1)
      begin errors++; $display("FAIL sat_pos got %0d sat=%b exp 32767 sat=1", got_dat[$], got_sat[$]); end
    run(-14'sd8192, 16, 1'b0, 1'b1);
    checks++; if (got_dat[$] !== 16'sh8000 || got_sat[$] !== 1'b1)
      begin errors++; $display("FAIL sat_neg got %0d sat=%b exp -32768 sat=1", got_dat[$], got_sat[$]); end
    run(14'sd0, 16, 1'b0, 1'b1);
    checks++; if (got_dat[$] !== 16'sd0 || got_sat[$] !== 1'b0)
      begin errors++; $display("FAIL sat_zero got %0d sat=%b exp 0 sat=0", got_dat[$], got_sat[$]); end
  endtask

  task automatic test_decimation();
    flush = 1'b1; tick(); flush = 1'b0;
    run(14'sd100, 40, 1'b0, 1'b1);
    checks++; if (got_t4.size() != 10) begin errors++; $display("FAIL dec4_count got %0d exp 10", got_t4.size()); end
    checks++; if (got_dat.size() != 40) begin errors++; $display("FAIL dec1_count got %0d exp 40", got_dat.size()); end
    checks++; if (got_t4[0] != 7) begin errors++; $display("FAIL dec4_first got t=%0d exp t=7", got_t4[0]); end
    for (int j = 1; j < got_t4.size(); j++) begin
      checks++;
      if (got_t4[j] - got_t4[j-1] != 4)
        begin errors++; $display("FAIL dec4_spacing[%0d] got %0d exp 4", j, got_t4[j] - got_t4[j-1]); end
    end
  endtask

  task automatic test_flush();
    load_coefs(1'b1);
    run(14'sd8191, 21, 1'b0, 1'b0);
    flush = 1'b1; din = 14'sd5000; din_valid = 1'b1;
    tick();
    flush = 1'b0; din_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      checks++;
      if (dout_valid !== 1'b0 || dout_valid4 !== 1'b0)
        begin errors++; $display("FAIL flush_quiet[%0d] got v=%b v4=%b exp 0 0", c, dout_valid, dout_valid4); end
    end
    checks++; if (dout !== 16'sd8191) begin errors++; $display("FAIL flush_hold got %0d exp 8191", dout); end
    feed_impulse();
    checks++; if (got_dat.size() != 16) begin errors++; $display("FAIL flush_imp_count got %0d exp 16", got_dat.size()); end
    checks++; if (got_dat[0] !== 16'sd28) begin errors++; $display("FAIL flush_imp_first got %0d exp 28", got_dat[0]); end
    checks++; if (got_dat[1] !== 16'sd61) begin errors++; $display("FAIL flush_imp_second got %0d exp 61", got_dat[1]); end
    checks++; if (got_t4[0] != 7) begin errors++; $display("FAIL flush_ph_restart got t=%0d exp t=7", got_t4[0]); end
  endtask

  task automatic test_coef_write();
    run(14'sd8191, 20, 1'b0, 1'b0);
    checks++; if (got_dat[$] !== 16'sd8191) begin errors++; $display("FAIL cw_before got %0d exp 8191", got_dat[$]); end
    coef_we = 1'b1; coef_addr = 3'd7; coef_wdata = 16'sd0;
    din = 14'sd8191; din_valid = 1'b1;
    tick();
    coef_we = 1'b0;
    run(14'sd8191, 20, 1'b0, 1'b1);
    checks++; if (got_dat.size() != 24) begin errors++; $display("FAIL cw_count got %0d exp 24", got_dat.size()); end
    checks++; if (got_dat[$] !== 16'sd5898 || got_sat[$] !== 1'b0)
      begin errors++; $display("FAIL cw_after got %0d sat=%b exp 5898 sat=0", got_dat[$], got_sat[$]); end
  endtask

  task automatic test_midstream_reset();
    int first;
    int stray;
    run(14'sd8191, 10, 1'b0, 1'b0);
    din_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    checks++; if (dout_valid !== 1'b0 || dout !== 16'sd0 || sat !== 1'b0)
      begin errors++; $display("FAIL async_reset got v=%b d=%0d s=%b exp 0 0 0", dout_valid, dout, sat); end
    tick(); tick();
    n_rst = 1'b1;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (dout_valid || dout_valid4) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL post_reset_stray got %0d exp 0", stray); end
    din = 14'sd1000; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    first = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (dout_valid && first < 0) first = c;
    end
    checks++; if (first != 4) begin errors++; $display("FAIL post_reset_latency got %0d exp 4", first); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; din = '0; din_valid = 1'b0; flush = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    @(negedge clk);
    test_reset();
    test_impulse();
    test_dc_stalls();
    test_saturation();
    test_decimation();
    test_flush();
    test_coef_write();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_filter_sym_dec.md
Name: fir_filter_sym_dec

Overview:
Parametrised symmetric-coefficient FIR with runtime-loadable coefficients, valid-qualified input, integer decimation and rounded/saturated output. Successor to the fixed 16-tap low-pass: it sits between the ADC front end and the demodulation/accumulation chain.
Symmetry folding halves the multipliers. Fixed pipeline latency. Intended for DSP-block mapping.

Parameters:
N, 16, tap count; must be even and >= 2
WIDTH, 14, signed input sample width
COEF_W, 16, signed coefficient width
OUT_W, 16, signed output width
SHIFT, 15, arithmetic right shift applied before output (0..ACC_W-1)
DECIM, 1, decimation factor, >= 1

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
din  in  WIDTH  signed input sample
din_valid  in  1  sample strobe; din is accepted on a rising clk edge while high
flush  in  1  synchronous clear of the data path and decimation phase
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(N/2)  half-table index k (taps k and N-1-k)
coef_wdata  in  COEF_W  signed coefficient value
dout  out  OUT_W  signed filtered, decimated sample
dout_valid  out  1  one-cycle strobe qualifying dout
sat  out  1  high with dout_valid when dout was clipped

Behaviour:
- Reset (n_rst low, asynchronous): tap delay line, all pipeline registers, valid pipeline, decimation counter, coefficient table, dout, dout_valid and sat all go to 0.
- Delay line: on accepted din, shifts tap[0]<=din, tap[i]<=tap[i-1]. It holds when din_valid is low. Idle cycles do not insert zeros.
- Widths: pre-add is WIDTH+1. Product is WIDTH+1+COEF_W. ACC_W = WIDTH+COEF_W+1+clog2(N/2). There is no internal overflow below the output stage.
- Pipeline, with the sample accepted at edge k:
  - edge k+1: pre-add p[j]=tap[j]+tap[N-1-j]
  - edge k+2: m[j]=p[j]*coef[j]
  - edge k+3: acc = sum of all m[j]
  - edge k+4: output stage
  - Latency is exactly 4 cycles. A valid bit travels alongside the data. Pipeline stages advance every cycle.
- Output stage:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT; when SHIFT=0, r = acc. This rounds half toward +inf.
  - If r > 2^(OUT_W-1)-1, dout = max and sat = 1. If r < -2^(OUT_W-1), dout = min and sat = 1. Otherwise dout = r and sat = 0.
  - dout and sat hold their values between strobes.
- Decimation:
  - Counter ph runs 0..DECIM-1 and increments on each accepted sample, wrapping to 0.
  - A sample accepted while ph==DECIM-1 is tagged. Only tagged samples raise dout_valid, 4 cycles later.
  - DECIM=1 tags every sample. After reset, the first output comes from the DECIM-th accepted sample.
- Coefficients:
  - coef_we writes coef[coef_addr] at the edge. The new value is used by the multiply stage from the next edge on.
  - In-flight samples may mix old and new coefficients; this is accepted.
  - Out-of-range addresses (N/2 not a power of 2) are ignored.
- flush:
  - At the edge, clears the delay line, valid pipeline and ph. dout_valid is 0 from the next cycle.
  - Coefficients and the held dout are kept.
  - flush dominates din_valid in the same cycle; that sample is dropped.
- Simultaneous coef_we and din_valid: both take effect; they are independent.
- Reset asserted mid-stream: all in-flight outputs are lost, and no dout_valid is emitted until 4 cycles after the first accepted sample post-reset (DECIM=1).

Test Plan:
- Reset: hold n_rst low, toggle din/din_valid -> dout=0, dout_valid=0, sat=0. Release, then one valid sample -> dout_valid first high exactly 4 edges after acceptance.
- Impulse (defaults): load coef[0..7]=112,243,618,1293,2217,3225,4089,4587, feed 8191 then 15 zeros, all valid -> 16 outputs starting 28, …, 1147, 1147, …, 28 (symmetric). Each value equals (8191*c+16384)>>15.
- DC and stalls: same coefficients (sum 32768), constant 8191 with din_valid toggling 1010… -> after 16 accepted samples, dout=8191 steadily. Constant -8192 -> -8192. Idle cycles produce no dout_valid.
- Saturation: all coef=32767, constant 8191 -> dout=32767, sat=1. Constant -8192 -> dout=-32768, sat=1. Constant 0 -> sat=0.
- Decimation DECIM=4: 40 consecutive valid samples -> exactly 10 dout_valid strobes, spaced 4 cycles apart. The first strobe follows the 4th sample by 4 cycles.
- flush and live coef write: flush mid-stream with din_valid high -> that sample dropped, no dout_valid 1..4 cycles later, ph restarts. Rewrite coef[7]=0 during DC 8191 -> output settles to (8191*(32768-9174)+16384)>>15 = 5898.
